// File: rtl/univ_shift_reg_if.sv
// Control and status bundle for univ_shift_reg. The tri-state parallel output q
// stays a plain port on the register itself so the high-Z drive is not routed through the interface.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             oe;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amt;
    logic             sin;
    logic [WIDTH-1:0] d;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output oe, start, mode, amt, sin, d,
        input  sout, busy, done
    );

    modport slave (
        input  oe, start, mode, amt, sin, d,
        output sout, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register. Multi-position shifts and rotates run one
// position per clock, and a start/busy/done handshake brackets each operation.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    univ_shift_reg_if.slave  bus,
    output tri   [WIDTH-1:0] q
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_ROL  = 3'b001,
        M_ROR  = 3'b010,
        M_LOAD = 3'b011,
        M_SHL  = 3'b100,
        M_SHR  = 3'b101,
        M_ASR  = 3'b110,
        M_RSVD = 3'b111
    } mode_e;

    typedef enum logic {S_IDLE, S_SHIFT} state_e;

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;

    mode_e            in_mode;
    logic             in_is_shift;

    assign in_mode     = mode_e'(bus.mode);
    assign in_is_shift = (in_mode inside {M_ROL, M_ROR, M_SHL, M_SHR, M_ASR});

    // One position of the selected operation; result is {bit shifted out, new register value}.
    function automatic logic [WIDTH:0] step(input mode_e m, input logic [WIDTH-1:0] r,
                                            input logic s);
        logic [WIDTH:0] res;
        res = {1'b0, r};
        case (m)
            M_ROL:   res = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
            M_ROR:   res = {r[0], r[0], r[WIDTH-1:1]};
            M_SHL:   res = {r[WIDTH-1], r[WIDTH-2:0], s};
            M_SHR:   res = {r[0], s, r[WIDTH-1:1]};
            M_ASR:   res = {r[0], r[WIDTH-1], r[WIDTH-1:1]};
            default: res = {1'b0, r};
        endcase
        return res;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= M_HOLD;
            cnt_q   <= '0;
            reg_q   <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            reg_q   <= reg_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every combinational output is given a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start && in_is_shift && (bus.amt != '0)) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        logic [WIDTH:0] stepped;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        reg_d   = reg_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        stepped = step(mode_q, reg_q, bus.sin);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (in_mode == M_LOAD) begin
                        reg_d  = bus.d;
                        done_d = 1'b1;
                    end else if (in_is_shift && (bus.amt != '0)) begin
                        // Shifting begins on the following edge, not on the start edge.
                        mode_d = in_mode;
                        cnt_d  = bus.amt;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                reg_d  = stepped[WIDTH-1:0];
                sout_d = stepped[WIDTH];
                cnt_d  = cnt_q - CNT_W'(1);
                done_d = (cnt_q == CNT_W'(1));
            end
            default: ;
        endcase
    end

    assign bus.busy = (state_q == S_SHIFT);
    assign bus.done = done_q;
    assign bus.sout = sout_q;
    assign q        = bus.oe ? {WIDTH{1'bz}} : reg_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: expected results are queued when an operation
// is launched and compared when its done pulse arrives.
module tb_univ_shift_reg;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    wire  [W-1:0] q;

    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .q   (q)
    );

    typedef struct {
        string      tag;
        logic [W-1:0] q;
        logic       sout;
        int         lat;
        int         busy_n;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [W-1:0] m_reg  = '0;
    logic         m_sout = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit is_shift(input logic [2:0] md);
        return md inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
    endfunction

    // Reference model: walks the operation one position at a time using plain shift operators.
    task automatic model_apply(input logic [2:0] md, input logic [CW-1:0] n,
                               input logic [W-1:0] dv, input logic s);
        logic b;
        if (md == 3'b011) begin
            m_reg = dv;
        end else if (is_shift(md)) begin
            for (int k = 0; k < int'(n); k++) begin
                case (md)
                    3'b001: begin b = m_reg[W-1]; m_reg = (m_reg << 1) | W'(b); end
                    3'b010: begin b = m_reg[0];   m_reg = (m_reg >> 1) | (W'(b) << (W-1)); end
                    3'b100: begin b = m_reg[W-1]; m_reg = (m_reg << 1) | W'(s); end
                    3'b101: begin b = m_reg[0];   m_reg = (m_reg >> 1) | (W'(s) << (W-1)); end
                    default: begin b = m_reg[0];  m_reg = W'($signed(m_reg) >>> 1); end
                endcase
                m_sout = b;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] md, input logic [CW-1:0] n,
                          input logic [W-1:0] dv, input logic s, input logic oe_v,
                          input bit inject);
        exp_t e;
        int   cycles;
        int   busy_n;
        @(negedge clk);
        bus.oe    = oe_v;
        bus.start = 1'b1;
        bus.mode  = md;
        bus.amt   = n;
        bus.d     = dv;
        bus.sin   = s;
        model_apply(md, n, dv, s);
        e.tag    = tag;
        e.q      = m_reg;
        e.sout   = m_sout;
        e.lat    = (is_shift(md) && n != '0) ? int'(n) + 1 : 1;
        e.busy_n = e.lat - 1;
        sb.push_back(e);

        @(negedge clk);
        bus.start = 1'b0;
        bus.mode  = 3'($urandom);
        bus.amt   = CW'($urandom);
        bus.d     = W'($urandom);
        cycles = 1;
        busy_n = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            if (bus.busy === 1'b1) busy_n++;
            if (inject && cycles == 2) begin
                bus.start = 1'b1;
                bus.mode  = 3'b011;
                bus.d     = 8'hFF;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;

        e = sb.pop_front();
        check({e.tag, " latency"}, cycles, e.lat);
        check({e.tag, " busy cycles"}, busy_n, e.busy_n);
        bus.oe = 1'b0;
        #1;
        check({e.tag, " q"}, q, e.q);
        check({e.tag, " sout"}, bus.sout, e.sout);
        @(negedge clk);
        check({e.tag, " done width"}, bus.done, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.oe    = 1'b0;
        bus.start = 1'b0;
        bus.mode  = '0;
        bus.amt   = '0;
        bus.sin   = 1'b0;
        bus.d     = '0;
        repeat (2) @(negedge clk);
        check("reset q", q, 8'h00);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset sout", bus.sout, 1'b0);
        rst = 1'b0;

        run_op("load_a5", 3'b011, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0);
        run_op("rol3", 3'b001, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0);
        check("rol3 plan q", q, 8'h2D);
        check("rol3 plan sout", bus.sout, 1'b1);

        run_op("load_90", 3'b011, 4'd0, 8'h90, 1'b0, 1'b0, 1'b0);
        run_op("asr2", 3'b110, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0);
        check("asr2 plan q", q, 8'hE4);

        run_op("load_81", 3'b011, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0);
        run_op("shl2", 3'b100, 4'd2, 8'h00, 1'b1, 1'b0, 1'b0);
        check("shl2 plan q", q, 8'h07);

        run_op("load_01", 3'b011, 4'd0, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op("ror10", 3'b010, 4'd10, 8'h00, 1'b0, 1'b0, 1'b0);
        check("ror10 plan q", q, 8'h40);
        run_op("ror0", 3'b010, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op("hold", 3'b000, 4'd5, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op("rsvd", 3'b111, 4'd5, 8'h00, 1'b0, 1'b0, 1'b0);

        run_op("ror4_oe", 3'b010, 4'd4, 8'h00, 1'b0, 1'b1, 1'b1);
        check("ror4_oe plan q", q, 8'h04);

        run_op("load_f3", 3'b011, 4'd0, 8'hF3, 1'b0, 1'b0, 1'b0);
        run_op("shr11", 3'b101, 4'd11, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("asr15", 3'b110, 4'd15, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), CW'($urandom_range(0, 12)),
                   W'($urandom), 1'($urandom), 1'b0, 1'b0);
        end

        // Reset landing in the middle of a 6-position shift.
        run_op("load_5a", 3'b011, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 3'b100;
        bus.amt   = 4'd6;
        bus.sin   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst q", q, 8'h00);
        check("midrst busy", bus.busy, 1'b0);
        check("midrst done", bus.done, 1'b0);
        check("midrst sout", bus.sout, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        m_reg  = '0;
        m_sout = 1'b0;
        @(negedge clk);
        check("postrst busy", bus.busy, 1'b0);
        run_op("load_3c", 3'b011, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("load_3c plan q", q, 8'h3C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
